// File: rtl/act_pipe.sv
// act_pipe: two-stage pipelined bias-subtract + activation for LANES lanes.
//   S1 register: per-lane d = sat(in - bias), plus the beat's mode and valid.
//   S2 register: per-lane y = f(d), plus valid; drives out_data/out_valid.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   bias_we, bias_in   load all per-lane bias registers
//   mode               00 identity, 01 ReLU, 10 logistic, 11 clip [0, ONE]
//   in_valid/in_ready  input handshake, in_data packed lanes (lane i at i*BITWIDTH)
//   out_valid/out_ready output handshake, out_data packed lanes (zero when idle)
module act_pipe #(
  parameter int BITWIDTH = 8,
  parameter int FRAC     = 4,
  parameter int LANES    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bias_we,
  input  logic [LANES*BITWIDTH-1:0] bias_in,
  input  logic [1:0]                mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*BITWIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*BITWIDTH-1:0] out_data
);

  localparam int W  = BITWIDTH;
  // Logistic works at 2^-(FRAC+5); the extra headroom covers a <= 2^(W-1) shifted by 3.
  localparam int LW = BITWIDTH + 7;

  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] ONE  = W'(1 << FRAC);

  localparam logic [1:0] MODE_ID   = 2'b00;
  localparam logic [1:0] MODE_RELU = 2'b01;
  localparam logic [1:0] MODE_LOG  = 2'b10;

  // Handshake / stall control
  logic       s1_valid_q, s1_valid_d;
  logic [1:0] s1_mode_q,  s1_mode_d;
  logic       s2_valid_q, s2_valid_d;
  logic       s1_adv, s2_adv;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s2_adv || !s1_valid_q;
  // Combinational from out_ready so a delivering pipeline can accept in the same cycle.
  assign in_ready = !rst && s1_adv;

  assign out_valid = s2_valid_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      s1_mode_d  = mode;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 2'b00;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : lane_g
      logic signed [W-1:0] bias_q, bias_d;
      logic signed [W-1:0] x;
      logic signed [W:0]   diff;
      logic signed [W-1:0] d_q, d_d;
      logic signed [W-1:0] y_q, y_d;
      logic        [W:0]   a;
      logic        [LW-1:0] a_w;
      logic        [LW-1:0] p_hr;
      logic        [W-1:0] p;

      assign x      = in_data[gi*W +: W];
      assign bias_d = bias_we ? bias_in[gi*W +: W] : bias_q;

      // Subtract in W+1 bits; differing top two bits mean the result left the W-bit range.
      assign diff = {x[W-1], x} - {bias_q[W-1], bias_q};

      always_comb begin
        d_d = diff[W-1:0];
        if (diff[W] != diff[W-1]) begin
          d_d = diff[W] ? SMIN : SMAX;
        end
      end

      // |d| in W+1 bits so the most-negative value does not wrap.
      assign a   = d_q[W-1] ? ({(W+1){1'b0}} - {d_q[W-1], d_q}) : {1'b0, d_q};
      assign a_w = {{6{1'b0}}, a};

      // Piecewise-linear logistic; a has FRAC fraction bits, p_hr has FRAC+5.
      always_comb begin
        if (a_w >= (LW'(5) << FRAC)) begin
          p_hr = LW'(32) << FRAC;                       // 1.0
        end else if ((a_w << 3) >= (LW'(19) << FRAC)) begin
          p_hr = a_w + (LW'(27) << FRAC);               // a/32 + 0.84375
        end else if (a_w >= (LW'(1) << FRAC)) begin
          p_hr = (a_w << 2) + (LW'(20) << FRAC);        // a/8 + 0.625
        end else begin
          p_hr = (a_w << 3) + (LW'(16) << FRAC);        // a/4 + 0.5
        end
      end

      assign p = W'(p_hr >> 5);

      always_comb begin
        y_d = '0;
        if (s1_valid_q) begin
          case (s1_mode_q)
            MODE_ID:   y_d = d_q;
            MODE_RELU: y_d = (!d_q[W-1] && (d_q != '0)) ? d_q : '0;
            MODE_LOG:  y_d = d_q[W-1] ? (ONE - $signed(p)) : $signed(p);
            default: begin
              if (d_q[W-1])      y_d = '0;
              else if (d_q > ONE) y_d = ONE;
              else               y_d = d_q;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          bias_q <= '0;
          d_q    <= '0;
          y_q    <= '0;
        end else begin
          bias_q <= bias_d;
          if (s1_adv) d_q <= d_d;
          if (s2_adv) y_q <= y_d;
        end
      end

      assign out_data[gi*W +: W] = y_q;
    end
  endgenerate

endmodule

// File: tb/tb_act_pipe.sv
// Directed testbench for act_pipe (BITWIDTH=8, FRAC=4, LANES=4).
module tb_act_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        bias_we;
  logic [31:0] bias_in;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks   = 0;
  int failures = 0;

  act_pipe #(.BITWIDTH(8), .FRAC(4), .LANES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bias_we   (bias_we),
    .bias_in   (bias_in),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  function automatic logic [31:0] bp_val(input int k);
    return pk(k*10+1, k*10+2, k*10+3, k*10+4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s ok observed=%h", tag, obs);
    end else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] m, input logic [31:0] din);
    in_valid = 1'b1;
    mode     = m;
    in_data  = din;
  endtask

  logic [31:0] exp_q[$];
  int sent, rcvd, cyc;
  logic acc;

  initial begin
    rst = 1'b1; bias_we = 1'b0; bias_in = '0; mode = 2'b00;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_out_data", out_data, 0);

    // Directed beats with mode changes each beat, no bubbles.
    beat(2'b10, pk(0, 16, -16, 80)); step();
    beat(2'b10, pk(40, 40, 40, 40)); bias_we = 1'b1; bias_in = pk(100, 100, 100, 100); step();
    chk("log_basic_v", out_valid, 1);
    chk("log_basic", out_data, pk(8, 12, 4, 16));
    bias_we = 1'b0;
    beat(2'b00, pk(-100, 127, 0, -28)); step();
    chk("log_40_oldbias", out_data, pk(14, 14, 14, 14));
    beat(2'b01, pk(-100, 127, 101, 99)); step();
    chk("id_sat_newbias", out_data, pk(-128, 27, -100, -128));
    beat(2'b11, pk(30, 127, 110, 100)); bias_we = 1'b1; bias_in = pk(0, 0, 0, 0); step();
    chk("relu_sat", out_data, pk(0, 27, 1, 0));
    bias_we = 1'b0;
    beat(2'b11, pk(30, -5, 16, 17)); step();
    chk("clip_oldbias", out_data, pk(0, 16, 10, 0));
    beat(2'b10, pk(-128, 127, -40, -1)); step();
    chk("clip_newbias", out_data, pk(16, 0, 16, 16));
    in_valid = 1'b0; step();
    chk("log_extremes", out_data, pk(0, 16, 2, 8));
    chk("log_extremes_v", out_valid, 1);
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_data", out_data, 0);

    // Backpressure: 6 identity beats, out_ready low for cycles 2..6.
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 6 && cyc < 40) begin
      in_valid  = (sent < 6);
      mode      = 2'b00;
      in_data   = bp_val(sent);
      out_ready = !(cyc >= 2 && cyc < 7);
      #1;
      acc = in_valid && in_ready;
      if (cyc >= 2 && cyc < 7) begin
        chk("bp_stall_in_ready", in_ready, 0);
        chk("bp_stall_valid", out_valid, 1);
        if (exp_q.size() > 0) chk("bp_stall_data", out_data, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra_beat", exp_q.size(), 1);
        end else begin
          chk("bp_deliver", out_data, exp_q.pop_front());
        end
        rcvd++;
      end
      if (acc) begin
        exp_q.push_back(bp_val(sent));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_received", rcvd, 6);
    chk("bp_sent", sent, 6);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_no_dup", out_valid, 0);

    // Reset with two beats in flight; nonzero bias loaded first.
    bias_we = 1'b1; bias_in = pk(7, 7, 7, 7);
    beat(2'b00, pk(50, 50, 50, 50)); step();
    bias_we = 1'b0;
    beat(2'b00, pk(51, 51, 51, 51)); step();
    chk("pre_rst_valid", out_valid, 1);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    step();
    chk("post_rst_valid1", out_valid, 0);
    step();
    chk("post_rst_valid2", out_valid, 0);
    beat(2'b00, pk(5, 5, 5, 5)); step();
    in_valid = 1'b0; step();
    chk("post_rst_bias0", out_data, pk(5, 5, 5, 5));
    chk("post_rst_bias0_v", out_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
